scalar_poplz_issue_ctl: RTL
===========================

Name: scalar_poplz_issue_ctl

Overview:
Issue and write-back controller for the scalar population/leading-zero count unit (instructions 026/027).
- Accepts one instruction per cycle from the issue stage and drives the unit's operand and opcode inputs.
- Tracks in-flight operations per latency slot and generates the A-register write strobe, address and data when each result emerges.
- Maintains an Ai reservation vector and blocks issue on A-write-port collisions and on result-mux hazards.

Parameters:
POP_LAT, 3, cycles from issue to valid pop-count result at i_fu_result
LZ_LAT, 2, cycles from issue to valid leading-zero result at i_fu_result
A_AW, 3, A-register address width (8 A registers)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_issue_valid  in  1  issue request
i_instr  in  7  opcode (7'o026 pop, 7'o027 lz)
i_dest  in  A_AW  destination Ai
i_sj  in  64  operand (Sj)
o_issue_ready  out  1  request accepted this cycle when high with i_issue_valid
o_fu_sj  out  64  operand to the functional unit
o_fu_instr  out  7  opcode to the functional unit; 7'b0 when idle
i_fu_result  in  24  functional unit result
o_a_we  out  1  A-register write strobe
o_a_addr  out  A_AW  A-register write address
o_a_data  out  24  A-register write data
o_a_resv  out  2**A_AW  Ai reservation bits: write pending
o_illegal  out  1  one-cycle pulse for an accepted non-026/027 opcode
o_busy  out  1  any operation in flight

Behaviour:
- Reset (async assert, sync deassert handled by rst_n): o_a_we=0, o_a_addr=0, o_a_data=0, o_a_resv=0, o_illegal=0, o_busy=0. All slot valids and last-op state are cleared. Operations in flight at reset are discarded and produce no write.
- Issue acceptance is "fire" = i_issue_valid & o_issue_ready in cycle t. o_fu_sj = i_sj and o_fu_instr = i_instr in cycle t (combinational). When not firing with a legal opcode, o_fu_instr = 0.
- o_issue_ready is low when any of the following holds:
  - (a) the slot register is already occupied at this opcode's latency (write-port collision);
  - (b) i_instr=027 and the previous cycle fired a 026 (the unit's output mux selects on the opcode 3 cycles old);
  - (c) o_a_resv[i_dest]=1 (WAW on Ai).
- o_issue_ready is combinational from state and i_instr/i_dest only, never from i_issue_valid.
- Slot register: entries 1..POP_LAT, each holding {valid, dest}. Every cycle entries shift toward slot 1. A fire writes slot POP_LAT (pop) or LZ_LAT (lz) after the shift.
- Write-back: when slot 1 is valid at the clock edge, o_a_we is asserted in the next cycle, with o_a_addr = slot dest and o_a_data = i_fu_result sampled that cycle. Net effect: pop fired at t → o_a_we in t+POP_LAT; lz fired at t → o_a_we in t+LZ_LAT.
- o_a_resv[d] is set in the cycle after the fire and cleared in the cycle after the o_a_we cycle. When the clear and a new fire to the same d fall on one edge, set wins. That case cannot occur because of (c); the verification bench asserts this.
- Illegal opcode: it fires (ready as if 026 for hazard purposes), no slot is allocated, o_fu_instr = 0, and o_illegal pulses in t+1.
- o_busy = OR of slot valids.
- Steady state: back-to-back pop every cycle and lz every cycle are both sustained with no bubbles. A pop→lz pair costs exactly one bubble. An lz→pop pair costs none.

Decomposition:
- Shared package: opcode constants OP_POP=7'o026 and OP_LZ=7'o027, POP_LAT/LZ_LAT defaults, and the slot entry typedef {valid, dest}.
- One sub-module is natural: poplz_slot_shift (parameterised depth slot register with insert-at-depth and slot-1 output).

Test Plan:
- Pop 0xFFFF_FFFF_FFFF_FFFF → A3, fired t=10 → o_a_we at t=13, addr 3, data 24'd64; o_a_resv[3] high cycles 11..13.
- Lz 0x0000_0001_0000_0000 → A5, fired t=10 → o_a_we at t=12, data 24'd31. Lz 0 → data 24'd64.
- Pop → A1 at t, lz → A2 requested at t+1 → ready low at t+1, lz fires at t+2. Writes occur at t+3 (A1) and t+4 (A2), never the same cycle.
- Lz → A1 at t, pop → A1 at t+1 → ready low until o_a_resv[1] clears. Pop fires at t+3 and writes at t+6.
- Reset asserted while two ops are in flight → all outputs 0 immediately. After release no o_a_we occurs, o_a_resv=0, and the next issue is accepted.
- Opcode 7'o025 requested → accepted, o_fu_instr=0, o_illegal pulse at t+1, no o_a_we.

Source files
------------

// File: rtl/scalar_poplz_issue_ctl_pkg.sv
// Shared opcodes, latency defaults and slot entry type for the scalar
// population / leading-zero count issue controller.
package scalar_poplz_issue_ctl_pkg;
    localparam logic [6:0] OP_POP = 7'o026;
    localparam logic [6:0] OP_LZ  = 7'o027;

    localparam int POP_LAT_DEF = 3;
    localparam int LZ_LAT_DEF  = 2;
    localparam int A_AW_DEF    = 3;

    typedef struct packed {
        logic                valid;
        logic [A_AW_DEF-1:0] dest;
    } slot_t;
endpackage

// File: rtl/scalar_poplz_issue_ctl_if.sv
// Issue-stage handshake into the pop/lz controller.
interface scalar_poplz_issue_ctl_if #(
    parameter int A_AW = 3
);
    logic            i_issue_valid;
    logic [6:0]      i_instr;
    logic [A_AW-1:0] i_dest;
    logic [63:0]     i_sj;
    logic            o_issue_ready;

    modport master (output i_issue_valid, i_instr, i_dest, i_sj, input o_issue_ready);
    modport slave  (input i_issue_valid, i_instr, i_dest, i_sj, output o_issue_ready);
endinterface

// File: rtl/scalar_poplz_issue_ctl_slot_shift.sv
// Latency slot register: entries shift toward slot 1 each cycle; a one-hot
// select inserts a new entry at its latency depth after the shift.
module poplz_slot_shift
    import scalar_poplz_issue_ctl_pkg::*;
#(
    parameter int DEPTH = POP_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DEPTH:1]      ins_sel,
    input  logic [A_AW_DEF-1:0] ins_dest,
    output slot_t [DEPTH:1]     slots
);
    slot_t [DEPTH:1] nxt;

    always_comb begin
        nxt = '0;
        for (int i = 1; i < DEPTH; i++) nxt[i] = slots[i+1];
        for (int i = 1; i <= DEPTH; i++)
            if (ins_sel[i]) nxt[i] = {1'b1, ins_dest};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slots <= '0;
        else        slots <= nxt;
    end
endmodule

// File: rtl/scalar_poplz_issue_ctl.sv
// Issue and A-register write-back control for the scalar pop/lz count unit
// (026/027): hazard checks, latency slot tracking and Ai reservations.
module scalar_poplz_issue_ctl
    import scalar_poplz_issue_ctl_pkg::*;
#(
    parameter int POP_LAT = POP_LAT_DEF,
    parameter int LZ_LAT  = LZ_LAT_DEF,
    parameter int A_AW    = A_AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scalar_poplz_issue_ctl_if.slave iss,
    output logic [63:0]          o_fu_sj,
    output logic [6:0]           o_fu_instr,
    input  logic [23:0]          i_fu_result,
    output logic                 o_a_we,
    output logic [A_AW-1:0]      o_a_addr,
    output logic [23:0]          o_a_data,
    output logic [2**A_AW-1:0]   o_a_resv,
    output logic                 o_illegal,
    output logic                 o_busy
);
    slot_t [POP_LAT:1]  slots;
    logic [POP_LAT:1]   ins_sel;
    logic [2**A_AW-1:0] resv_set, resv_clr;
    logic is_pop, is_lz, legal, lz_coll, last_pop, fire;

    assign is_pop = (iss.i_instr == OP_POP);
    assign is_lz  = (iss.i_instr == OP_LZ);
    assign legal  = is_pop | is_lz;

    // A pop sits one slot above the lz insert point in the cycle after it
    // fires, so an lz then would share its write-back cycle.
    generate
        if (LZ_LAT < POP_LAT) begin : g_lz_coll
            assign lz_coll = slots[LZ_LAT+1].valid;
        end else begin : g_no_coll
            assign lz_coll = 1'b0;
        end
    endgenerate

    // Illegal opcodes see the pop hazard rules: no slot collision possible.
    assign iss.o_issue_ready = !(is_lz & lz_coll) && !(is_lz & last_pop) &&
                               !o_a_resv[iss.i_dest];
    assign fire = iss.i_issue_valid & iss.o_issue_ready;

    assign o_fu_sj    = iss.i_sj;
    assign o_fu_instr = (fire & legal) ? iss.i_instr : 7'd0;

    always_comb begin
        ins_sel = '0;
        if (fire & is_pop) ins_sel[POP_LAT] = 1'b1;
        if (fire & is_lz)  ins_sel[LZ_LAT]  = 1'b1;
    end

    poplz_slot_shift #(.DEPTH(POP_LAT)) u_slots (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins_sel  (ins_sel),
        .ins_dest (iss.i_dest),
        .slots    (slots)
    );

    // Slot 1 holds the op whose result is on i_fu_result this cycle.
    assign o_a_we   = slots[1].valid;
    assign o_a_addr = slots[1].dest;
    assign o_a_data = o_a_we ? i_fu_result : 24'd0;

    always_comb begin
        o_busy = 1'b0;
        for (int i = 1; i <= POP_LAT; i++) o_busy = o_busy | slots[i].valid;
    end

    always_comb begin
        resv_set = '0;
        resv_clr = '0;
        if (fire & legal) resv_set[iss.i_dest] = 1'b1;
        if (o_a_we)       resv_clr[o_a_addr]   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_a_resv  <= '0;
            last_pop  <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            o_a_resv  <= (o_a_resv & ~resv_clr) | resv_set;
            last_pop  <= fire & is_pop;
            o_illegal <= fire & ~legal;
        end
    end
endmodule
